// File: rtl/sdram_responder.sv
// sdram_responder: behavioural-but-synthesizable model of an MT48LC16M16-class
// SDRAM device. It decodes the command bus, tracks open rows per bank, holds
// the mode register, stores data in internal RAM, returns read data after the
// programmed CAS latency and reports protocol violations as sticky flags.
//
// Ports:
//   clk          - single clock, all sd_* inputs sampled on its rising edge
//   reset_n      - asynchronous active-low reset
//   sd_data      - bidirectional data bus, driven only during read return
//   sd_addr      - row / column / mode address
//   sd_dqm       - byte masks (bit1 upper, bit0 lower, 1 = masked)
//   sd_ba        - bank select
//   sd_cs/ras/cas/we - command = {cs,ras,cas,we}
//   mode_reg     - last loaded mode word
//   mode_valid   - a LOAD_MODE has been accepted
//   refresh_cnt  - saturating AUTO_REFRESH count
//   err          - sticky violation flags
module sdram_responder #(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 9,
  parameter int unsigned TRCD_MIN = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  inout  wire  [15:0] sd_data,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_dqm,
  input  logic [1:0]  sd_ba,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  output logic [12:0] mode_reg,
  output logic        mode_valid,
  output logic [15:0] refresh_cnt,
  output logic [4:0]  err
);

  localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = (TRCD_MIN < 1) ? 1 : $clog2(TRCD_MIN + 1);

  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  // Bank / mode state
  logic [3:0]          r_open;
  logic [ROW_BITS-1:0] r_row  [4];
  logic [CW-1:0]       r_trcd [4];
  logic                r_cl3;
  logic [12:0]         r_mode_reg;
  logic                r_mode_valid;
  logic [15:0]         r_refresh_cnt;
  logic [4:0]          r_err;

  // Read return pipe; entry 0 is the one currently on the bus
  logic [2:0]  r_pv;
  logic [1:0]  r_pm [3];
  logic [15:0] r_pd [3];

  logic [15:0] r_mem [DEPTH];

  // Command decode
  logic [3:0]    w_cmd;
  logic          w_is_act, w_is_rd, w_is_wr, w_is_pre, w_is_ref, w_is_lmr, w_is_rw;
  logic          w_bank_open, w_any_open, w_trcd_ok, w_mode_ok, w_access_ok;
  logic          w_do_rd, w_do_wr;
  logic [4:0]    w_err_set;
  logic [AW-1:0] w_idx;

  assign w_cmd    = {sd_cs, sd_ras, sd_cas, sd_we};
  assign w_is_act = (w_cmd == CMD_ACTIVE);
  assign w_is_rd  = (w_cmd == CMD_READ);
  assign w_is_wr  = (w_cmd == CMD_WRITE);
  assign w_is_pre = (w_cmd == CMD_PRECHARGE);
  assign w_is_ref = (w_cmd == CMD_REFRESH);
  assign w_is_lmr = (w_cmd == CMD_LOAD_MODE);
  assign w_is_rw  = w_is_rd | w_is_wr;

  assign w_bank_open = r_open[sd_ba];
  assign w_any_open  = |r_open;
  // Counter restarts at 0 on ACTIVE, so clocks elapsed at this edge is count+1
  assign w_trcd_ok   = (32'(r_trcd[sd_ba]) + 32'd1) >= TRCD_MIN;
  assign w_mode_ok   = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) &&
                       (sd_addr[2:0] == 3'd0) && sd_addr[9];
  assign w_access_ok = w_bank_open & w_trcd_ok & r_mode_valid;
  assign w_do_rd     = w_is_rd & w_access_ok;
  assign w_do_wr     = w_is_wr & w_access_ok;
  assign w_idx       = {sd_ba, r_row[sd_ba], sd_addr[COL_BITS-1:0]};

  // Violation flags raised on this edge
  always_comb begin
    w_err_set    = '0;
    w_err_set[0] = (w_is_act & w_bank_open) | (w_is_rw & ~w_bank_open) |
                   ((w_is_ref | w_is_lmr) & w_any_open);
    w_err_set[1] = w_is_rw & w_bank_open & ~w_trcd_ok;
    w_err_set[2] = w_is_lmr & ~w_mode_ok;
    w_err_set[3] = w_is_rw & ~r_mode_valid;
    // Pipe entry 1 goes on the bus right after this edge, entry 0 is on it now
    w_err_set[4] = w_is_wr & (r_pv[0] | r_pv[1]);
  end

  // Bank, mode, refresh and error state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open        <= '0;
      for (int b = 0; b < 4; b++) begin
        r_row[b]  <= '0;
        r_trcd[b] <= '0;
      end
      r_cl3         <= 1'b0;
      r_mode_reg    <= '0;
      r_mode_valid  <= 1'b0;
      r_refresh_cnt <= '0;
      r_err         <= '0;
    end else begin
      r_err <= r_err | w_err_set;

      for (int b = 0; b < 4; b++) begin
        if (r_trcd[b] != CW'(TRCD_MIN)) r_trcd[b] <= r_trcd[b] + CW'(1);
      end

      if (w_is_act) begin
        r_open[sd_ba] <= 1'b1;
        r_row[sd_ba]  <= sd_addr[ROW_BITS-1:0];
        r_trcd[sd_ba] <= '0;
      end

      if (w_is_rw && sd_addr[10]) r_open[sd_ba] <= 1'b0;

      if (w_is_pre) begin
        if (sd_addr[10]) r_open <= '0;
        else             r_open[sd_ba] <= 1'b0;
      end

      if (w_is_ref && (r_refresh_cnt != 16'hFFFF)) r_refresh_cnt <= r_refresh_cnt + 16'd1;

      if (w_is_lmr) begin
        r_mode_reg   <= sd_addr;
        r_mode_valid <= 1'b1;
        // Unsupported modes fall back to CL=2
        r_cl3        <= w_mode_ok & (sd_addr[6:4] == 3'd3);
      end
    end
  end

  // Read pipe control: CL=2 enters one stage from the bus, CL=3 two stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pv <= '0;
      for (int k = 0; k < 3; k++) r_pm[k] <= '0;
    end else begin
      r_pv    <= {1'b0, r_pv[2:1]};
      r_pm[0] <= r_pm[1];
      r_pm[1] <= r_pm[2];
      r_pm[2] <= '0;
      if (w_do_rd) begin
        if (r_cl3) begin
          r_pv[2] <= 1'b1;
          r_pm[2] <= sd_dqm;
        end else begin
          r_pv[1] <= 1'b1;
          r_pm[1] <= sd_dqm;
        end
      end
    end
  end

  // Read pipe data; no reset needed, qualified by r_pv
  always_ff @(posedge clk) begin
    r_pd[0] <= r_pd[1];
    r_pd[1] <= r_pd[2];
    r_pd[2] <= r_pd[2];
    if (w_do_rd) begin
      if (r_cl3) r_pd[2] <= r_mem[w_idx];
      else       r_pd[1] <= r_mem[w_idx];
    end
  end

  // Byte-masked storage; contents survive reset
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      if (!sd_dqm[0]) r_mem[w_idx][7:0]  <= sd_data[7:0];
      if (!sd_dqm[1]) r_mem[w_idx][15:8] <= sd_data[15:8];
    end
  end

  assign sd_data[7:0]  = (r_pv[0] && !r_pm[0][0]) ? r_pd[0][7:0]  : 8'hzz;
  assign sd_data[15:8] = (r_pv[0] && !r_pm[0][1]) ? r_pd[0][15:8] : 8'hzz;

  assign mode_reg    = r_mode_reg;
  assign mode_valid  = r_mode_valid;
  assign refresh_cnt = r_refresh_cnt;
  assign err         = r_err;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder. The data bus is a pulled-up net, so a
// released (Z) byte reads back as 8'hFF; test data never uses 8'hFF bytes.
module tb_sdram_responder;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [15:0] BUS_Z = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  tri1  [15:0] sd_data;
  logic [12:0] sd_addr = '0;
  logic [1:0]  sd_dqm = '0;
  logic [1:0]  sd_ba = '0;
  logic        sd_cs = 1'b0, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
  logic [12:0] mode_reg;
  logic        mode_valid;
  logic [15:0] refresh_cnt;
  logic [4:0]  err;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dout = '0;
  int          n_vec = 0;
  int          n_err = 0;

  assign sd_data = tb_oe ? tb_dout : 16'hzzzz;

  always #5 clk = ~clk;

  sdram_responder #(.ROW_BITS(4), .COL_BITS(9), .TRCD_MIN(2)) dut (
    .clk(clk), .reset_n(reset_n), .sd_data(sd_data), .sd_addr(sd_addr),
    .sd_dqm(sd_dqm), .sd_ba(sd_ba), .sd_cs(sd_cs), .sd_ras(sd_ras),
    .sd_cas(sd_cas), .sd_we(sd_we), .mode_reg(mode_reg), .mode_valid(mode_valid),
    .refresh_cnt(refresh_cnt), .err(err)
  );

  // Present one command for one rising edge; returns 2 ns after that edge
  task automatic issue(input logic [3:0] cmd, input logic [1:0] ba,
                       input logic [12:0] addr, input logic [1:0] dqm,
                       input logic [15:0] wdata);
    {sd_cs, sd_ras, sd_cas, sd_we} = cmd;
    sd_ba = ba; sd_addr = addr; sd_dqm = dqm; tb_dout = wdata;
    tb_oe = (cmd == WR);
    @(posedge clk); #1;
    {sd_cs, sd_ras, sd_cas, sd_we} = NOP;
    sd_dqm = '0; tb_oe = 1'b0;
    #1;
  endtask

  task automatic nop();
    issue(NOP, 2'd0, 13'd0, 2'b00, 16'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if (mode_reg !== 13'h0) begin n_err++; $display("FAIL reset_mode_reg got=%h exp=%h", mode_reg, 13'h0); end
    n_vec++; if (mode_valid !== 1'b0) begin n_err++; $display("FAIL reset_mode_valid got=%b exp=0", mode_valid); end
    n_vec++; if (refresh_cnt !== 16'h0) begin n_err++; $display("FAIL reset_refresh got=%h exp=0", refresh_cnt); end
    n_vec++; if (err !== 5'b0) begin n_err++; $display("FAIL reset_err got=%b exp=00000", err); end
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL reset_bus got=%h exp=%h", sd_data, BUS_Z); end
    reset_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_init();
    issue(PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    issue(LMR, 2'd0, 13'h220, 2'b00, 16'd0);
    n_vec++; if (mode_reg !== 13'h220) begin n_err++; $display("FAIL init_mode_reg got=%h exp=%h", mode_reg, 13'h220); end
    n_vec++; if (mode_valid !== 1'b1) begin n_err++; $display("FAIL init_mode_valid got=%b exp=1", mode_valid); end
    n_vec++; if (err !== 5'b0) begin n_err++; $display("FAIL init_err got=%b exp=00000", err); end
  endtask

  task automatic test_write_read();
    issue(ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop(); nop(); nop();
    issue(WR, 2'd1, 13'h41A, 2'b00, 16'hA55A);
    issue(ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop();
    issue(RD, 2'd1, 13'h01A, 2'b00, 16'd0);
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL wr_rd_t0 got=%h exp=%h", sd_data, BUS_Z); end
    nop();
    n_vec++; if (sd_data !== 16'hA55A) begin n_err++; $display("FAIL wr_rd_t1 got=%h exp=%h", sd_data, 16'hA55A); end
    nop();
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL wr_rd_t2 got=%h exp=%h", sd_data, BUS_Z); end
    n_vec++; if (err !== 5'b0) begin n_err++; $display("FAIL wr_rd_err got=%b exp=00000", err); end
  endtask

  task automatic test_masks();
    issue(WR, 2'd1, 13'h01A, 2'b10, 16'h1234);
    issue(RD, 2'd1, 13'h01A, 2'b00, 16'd0);
    nop();
    n_vec++; if (sd_data !== 16'hA534) begin n_err++; $display("FAIL mask_write got=%h exp=%h", sd_data, 16'hA534); end
    nop();
    issue(RD, 2'd1, 13'h01A, 2'b01, 16'd0);
    nop();
    n_vec++; if (sd_data !== 16'hA5FF) begin n_err++; $display("FAIL mask_read got=%h exp=%h", sd_data, 16'hA5FF); end
    nop();
  endtask

  task automatic test_back_to_back();
    issue(WR, 2'd1, 13'h002, 2'b00, 16'hBEEF);
    issue(RD, 2'd1, 13'h002, 2'b00, 16'd0);
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL b2b_t0 got=%h exp=%h", sd_data, BUS_Z); end
    issue(RD, 2'd1, 13'h01A, 2'b00, 16'd0);
    n_vec++; if (sd_data !== 16'hBEEF) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", sd_data, 16'hBEEF); end
    nop();
    n_vec++; if (sd_data !== 16'hA534) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", sd_data, 16'hA534); end
    nop();
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL b2b_release got=%h exp=%h", sd_data, BUS_Z); end
  endtask

  task automatic test_violations();
    issue(RD, 2'd2, 13'h000, 2'b00, 16'd0);
    n_vec++; if (err !== 5'b00001) begin n_err++; $display("FAIL viol_closed_err got=%b exp=00001", err); end
    nop();
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL viol_closed_bus got=%h exp=%h", sd_data, BUS_Z); end
    nop();
    issue(ACT, 2'd3, 13'd7, 2'b00, 16'd0);
    issue(RD, 2'd3, 13'h000, 2'b00, 16'd0);
    n_vec++; if (err !== 5'b00011) begin n_err++; $display("FAIL viol_trcd_err got=%b exp=00011", err); end
    nop();
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL viol_trcd_bus got=%h exp=%h", sd_data, BUS_Z); end
    nop();
    issue(RD, 2'd1, 13'h01A, 2'b00, 16'd0);
    issue(WR, 2'd1, 13'h003, 2'b00, 16'h5555);
    n_vec++; if (err !== 5'b10011) begin n_err++; $display("FAIL viol_bus_err got=%b exp=10011", err); end
    n_vec++; if (sd_data !== 16'hA534) begin n_err++; $display("FAIL viol_bus_rd got=%h exp=%h", sd_data, 16'hA534); end
    nop();
    issue(RD, 2'd1, 13'h003, 2'b00, 16'd0);
    nop();
    n_vec++; if (sd_data !== 16'h5555) begin n_err++; $display("FAIL viol_bus_wr_done got=%h exp=%h", sd_data, 16'h5555); end
    nop();
  endtask

  task automatic test_no_mode();
    do_reset();
    n_vec++; if (err !== 5'b0) begin n_err++; $display("FAIL nomode_reset_err got=%b exp=00000", err); end
    issue(ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop(); nop();
    issue(WR, 2'd1, 13'h01A, 2'b00, 16'h7777);
    n_vec++; if (err !== 5'b01000) begin n_err++; $display("FAIL nomode_err got=%b exp=01000", err); end
    issue(PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    issue(LMR, 2'd0, 13'h220, 2'b00, 16'd0);
    issue(ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop();
    issue(RD, 2'd1, 13'h01A, 2'b00, 16'd0);
    nop();
    n_vec++; if (sd_data !== 16'hA534) begin n_err++; $display("FAIL nomode_mem_kept got=%h exp=%h", sd_data, 16'hA534); end
    nop();
  endtask

  task automatic test_cl3_refresh();
    do_reset();
    issue(PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    issue(LMR, 2'd0, 13'h230, 2'b00, 16'd0);
    n_vec++; if (mode_reg !== 13'h230) begin n_err++; $display("FAIL cl3_mode_reg got=%h exp=%h", mode_reg, 13'h230); end
    issue(ACT, 2'd0, 13'd2, 2'b00, 16'd0);
    nop();
    issue(WR, 2'd0, 13'h005, 2'b00, 16'hC3C3);
    issue(RD, 2'd0, 13'h005, 2'b00, 16'd0);
    nop();
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL cl3_t1 got=%h exp=%h", sd_data, BUS_Z); end
    nop();
    n_vec++; if (sd_data !== 16'hC3C3) begin n_err++; $display("FAIL cl3_t2 got=%h exp=%h", sd_data, 16'hC3C3); end
    nop();
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL cl3_t3 got=%h exp=%h", sd_data, BUS_Z); end
    issue(PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    for (int i = 0; i < 3; i++) issue(REF, 2'd0, 13'd0, 2'b00, 16'd0);
    n_vec++; if (refresh_cnt !== 16'd3) begin n_err++; $display("FAIL refresh_cnt got=%0d exp=3", refresh_cnt); end
    n_vec++; if (err !== 5'b0) begin n_err++; $display("FAIL cl3_err got=%b exp=00000", err); end
  endtask

  task automatic test_reset_mid_read();
    issue(LMR, 2'd0, 13'h030, 2'b00, 16'd0);
    n_vec++; if (err !== 5'b00100) begin n_err++; $display("FAIL badmode_err got=%b exp=00100", err); end
    issue(ACT, 2'd0, 13'd2, 2'b00, 16'd0);
    nop();
    issue(RD, 2'd0, 13'h005, 2'b00, 16'd0);
    nop();
    n_vec++; if (sd_data !== 16'hC3C3) begin n_err++; $display("FAIL badmode_cl2 got=%h exp=%h", sd_data, 16'hC3C3); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL rst_mid_bus got=%h exp=%h", sd_data, BUS_Z); end
    n_vec++; if (err !== 5'b0) begin n_err++; $display("FAIL rst_mid_err got=%b exp=00000", err); end
    n_vec++; if (mode_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_mode_valid got=%b exp=0", mode_valid); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nop();
      n_vec++; if (sd_data !== BUS_Z) begin n_err++; $display("FAIL rst_after_bus%0d got=%h exp=%h", i, sd_data, BUS_Z); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_masks();
    test_back_to_back();
    test_violations();
    test_no_mode();
    test_cl3_refresh();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable SDRAM device responder that models the MT48LC16M16-class chip on the far side of the team's SDRAM controller.
- Decodes the command bus, tracks per-bank open rows, captures the mode register and stores write data in internal block RAM.
- Returns read data after the programmed CAS latency and flags protocol violations through sticky error bits.
- Used in simulation benches and in FPGA self-test builds in place of the physical chip.

Parameters:
- ROW_BITS, 4: low row-address bits kept for memory indexing; 1..13.
- COL_BITS, 9: column-address bits used; 1..9.
- TRCD_MIN, 2: minimum clocks from ACTIVE to READ/WRITE on the same bank.

Ports:
- clk, input, 1: single clock; all sd_* inputs are sampled on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- sd_data, inout, 16: data bus; driven only during read return, otherwise Z.
- sd_addr, input, 13: multiplexed row/column/mode address.
- sd_dqm, input, 2: byte masks; bit1 = upper byte, bit0 = lower byte; 1 = masked.
- sd_ba, input, 2: bank select.
- sd_cs, sd_ras, sd_cas, sd_we, input, 1 each: command = {cs,ras,cas,we}.
- mode_reg, output, 13: last loaded mode word.
- mode_valid, output, 1: a LOAD_MODE has been accepted.
- refresh_cnt, output, 16: AUTO_REFRESH count; saturates at 16'hFFFF.
- err, output, 5: sticky violation flags.

Behaviour:
- Reset (async): all banks closed, rows 0, tRCD counters 0, read pipe flushed, sd_data Z immediately.
- Reset outputs: mode_reg 0, mode_valid 0, refresh_cnt 0, err 0. Memory contents are not cleared.
- Command decode, per clock edge:
  - 1xxx INHIBIT, 0111 NOP, 0110 BURST_TERMINATE: no action.
  - 0011 ACTIVE: open bank ba, latch row = sd_addr, restart that bank's tRCD counter.
  - 0101 READ / 0100 WRITE: column = sd_addr[COL_BITS-1:0]; word index = {ba, row[ROW_BITS-1:0], column}. If sd_addr[10]=1 (auto-precharge), the bank closes after the access.
  - 0010 PRECHARGE: sd_addr[10]=1 closes all banks; otherwise closes bank ba. Precharging a closed bank is legal.
  - 0001 AUTO_REFRESH: increments refresh_cnt.
  - 0000 LOAD_MODE: mode_reg <= sd_addr, mode_valid <= 1.
- WRITE: din = sd_data sampled on the same edge. A byte is written only when its dqm bit is 0.
- READ:
  - Latency CL = mode_reg[6:4], valid values 2 or 3.
  - READ sampled at edge T0: the responder drives the word from just after edge T(CL-1) until just after edge T(CL), so it is valid at edge T(CL).
  - Bytes whose sd_dqm bit was 1 at the READ edge drive Z.
  - Back-to-back READs pipeline with 1-cycle spacing.
- Errors: each bit is set on the offending edge and held until reset. An illegal command still executes as far as possible: it updates state but performs no memory access.
  - err[0] bank-state violation: ACTIVE to an open bank; READ/WRITE to a closed bank; AUTO_REFRESH or LOAD_MODE while any bank is open.
  - err[1] tRCD violation: READ/WRITE fewer than TRCD_MIN clocks after that bank's ACTIVE.
  - err[2] unsupported mode: LOAD_MODE with CL not in {2,3}, burst length mode[2:0] != 000, or mode[9] = 0. Latency then uses CL=2.
  - err[3] access before mode_valid: READ/WRITE while mode_valid = 0; no memory access.
  - err[4] bus contention: WRITE sampled while the read pipe is driving, or will drive, sd_data in that cycle. The write is still performed.
- Simultaneous events:
  - Auto-precharge close and a new ACTIVE on the next edge are legal.
  - A READ immediately after a WRITE to the same word returns the new data (write-first).
- tRCD counters saturate at TRCD_MIN.

Test Plan:
- Init sequence: PRECHARGE with A10=1, then LOAD_MODE 13'h220 -> mode_reg=13'h220, mode_valid=1, err=0.
- Write/read: ACTIVE ba=1 row=5; wait 3 clocks; WRITE col=0x1A data 16'hA55A, A10=1; ACTIVE again; READ col=0x1A -> 16'hA55A driven exactly 2 clocks after READ; sd_data Z otherwise.
- Masks: WRITE 16'h1234 with dqm=2'b10 over existing 16'hA55A -> read returns 16'hA534; READ with dqm=2'b01 -> lower byte Z.
- Violations: READ to a closed bank -> err[0]=1; READ 1 clock after ACTIVE with TRCD_MIN=2 -> err[1]=1; WRITE before any LOAD_MODE -> err[3]=1 and memory unchanged.
- CL=3 and refresh: LOAD_MODE 13'h230 -> read data appears 3 clocks after READ; 3 AUTO_REFRESH commands with all banks closed -> refresh_cnt=3.
- Reset mid-read: assert reset_n low one cycle after a READ -> sd_data Z immediately, err=0, mode_valid=0, no data driven after release.
